// File: rtl/adder_pkg.sv
// ============================================================================
// Module      : adder_pkg
// Description : Shared state encoding and sizing helpers for multicycle_adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } adder_state_e;

    function automatic int calc_nchunk(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

    // Counter is at least one bit wide even when a single chunk covers WIDTH.
    function automatic int calc_idx_width(input int width, input int chunk);
        int n;
        n = calc_nchunk(width, chunk);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/chunk_adder.sv
// ============================================================================
// Module      : chunk_adder
// Description : Combinational CHUNK-bit adder with carry in/out and the carry
//               into the MSB (used for signed overflow detection).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum    = w_full[CHUNK-1:0];
    assign cout   = w_full[CHUNK];
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly.
    assign cmsb   = a[CHUNK-1] ^ b[CHUNK-1] ^ w_full[CHUNK-1];

endmodule

`default_nettype wire

// File: rtl/multicycle_adder.sv
// ============================================================================
// Module      : multicycle_adder
// Description : Valid/ready multi-cycle ripple adder, CHUNK bits per clock.
//               Define MULTICYCLE_ADDER_OVF_EN to add the signed 'ovf' output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef MULTICYCLE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int c_nchunk = calc_nchunk(WIDTH, CHUNK);
    localparam int c_idx_w  = calc_idx_width(WIDTH, CHUNK);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_nchunk - 1);

    generate
        if ((CHUNK < 1) || ((WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0)) begin : g_param_check
            $error("multicycle_adder: CHUNK must be >= 1 and divide WIDTH");
        end
    endgenerate

    adder_state_e        r_state;
    adder_state_e        w_next_state;
    logic [c_idx_w-1:0]  r_idx;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic                r_carry;
    logic [WIDTH-1:0]    r_sum;
    logic                r_cout;
    logic [CHUNK-1:0]    w_a_chunk;
    logic [CHUNK-1:0]    w_b_chunk;
    logic [CHUNK-1:0]    w_s;
    logic                w_c;
    logic                w_cmsb;
    logic                w_last;

    assign w_a_chunk = r_a[int'(r_idx)*CHUNK +: CHUNK];
    assign w_b_chunk = r_b[int'(r_idx)*CHUNK +: CHUNK];
    assign w_last    = (r_idx == c_last_idx);

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a    (w_a_chunk),
        .b    (w_b_chunk),
        .cin  (r_carry),
        .sum  (w_s),
        .cout (w_c),
        .cmsb (w_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next_state = BUSY;
            end
            BUSY: begin
                if (w_last) w_next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

`ifdef MULTICYCLE_ADDER_OVF_EN
    logic r_ovf;
    assign ovf = r_ovf;
`else
    logic w_cmsb_unused;
    assign w_cmsb_unused = w_cmsb;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
`ifdef MULTICYCLE_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                    end
                end
                BUSY: begin
                    r_sum[int'(r_idx)*CHUNK +: CHUNK] <= w_s;
                    r_carry <= w_c;
                    if (w_last) begin
                        r_idx  <= '0;
                        r_cout <= w_c;
`ifdef MULTICYCLE_ADDER_OVF_EN
                        r_ovf  <= w_cmsb ^ w_c;
`endif
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_adder.sv
// ============================================================================
// Module      : tb_multicycle_adder
// Description : Randomized self-checking bench for multicycle_adder across
//               several WIDTH/CHUNK configurations (ovf with the macro).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_adder;

`ifdef MULTICYCLE_ADDER_OVF_EN
    localparam int NDUT = 4;
`else
    localparam int NDUT = 3;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     [NDUT];
    logic        in_valid  [NDUT];
    logic        in_ready  [NDUT];
    logic        cin       [NDUT];
    logic        out_valid [NDUT];
    logic        out_ready [NDUT];
    logic        cout      [NDUT];
    logic [31:0] a32, b32, sum32;
    logic [7:0]  a8   [NDUT];
    logic [7:0]  b8   [NDUT];
    logic [7:0]  sum8 [NDUT];
`ifdef MULTICYCLE_ADDER_OVF_EN
    logic        ovf  [NDUT];
`endif

    int wid [4] = '{32, 8, 8, 8};
    int nch [4] = '{4, 4, 1, 2};

    int n_vec  = 0;
    int n_miss = 0;

    multicycle_adder #(.WIDTH(32), .CHUNK(8)) u_w32c8 (
        .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a32), .b(b32), .cin(cin[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum32), .cout(cout[0])
`ifdef MULTICYCLE_ADDER_OVF_EN
        , .ovf(ovf[0])
`endif
    );

    multicycle_adder #(.WIDTH(8), .CHUNK(2)) u_w8c2 (
        .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a8[1]), .b(b8[1]), .cin(cin[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum8[1]), .cout(cout[1])
`ifdef MULTICYCLE_ADDER_OVF_EN
        , .ovf(ovf[1])
`endif
    );

    multicycle_adder #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
        .clk(clk), .rst_n(rst_n[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a8[2]), .b(b8[2]), .cin(cin[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .sum(sum8[2]), .cout(cout[2])
`ifdef MULTICYCLE_ADDER_OVF_EN
        , .ovf(ovf[2])
`endif
    );

`ifdef MULTICYCLE_ADDER_OVF_EN
    multicycle_adder #(.WIDTH(8), .CHUNK(4)) u_w8c4 (
        .clk(clk), .rst_n(rst_n[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .a(a8[3]), .b(b8[3]), .cin(cin[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
        .sum(sum8[3]), .cout(cout[3]), .ovf(ovf[3])
    );
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] get_result(input int d);
        logic [63:0] s;
        s = (d == 0) ? 64'(sum32) : 64'(sum8[d]);
        return (64'(cout[d]) << wid[d]) | s;
    endfunction

    task automatic set_ops(input int d, input logic [31:0] aa, input logic [31:0] bb);
        if (d == 0) begin
            a32 = aa;
            b32 = bb;
        end else begin
            a8[d] = aa[7:0];
            b8[d] = bb[7:0];
        end
    endtask

    // One full transaction on DUT d; 'hold' cycles of backpressure in DONE.
    task automatic run_txn(input int d, input logic [31:0] aa, input logic [31:0] bb,
                           input logic c, input int hold);
        logic [63:0] mask, exp;
        int          lat;
        bit          ready_leak;
`ifdef MULTICYCLE_ADDER_OVF_EN
        int          ssum;
        logic        exp_ovf;
`endif
        mask = (64'd1 << wid[d]) - 64'd1;
        exp  = (64'(aa) & mask) + (64'(bb) & mask) + 64'(c);
        check($sformatf("in_ready_idle[%0d]", d), 64'(in_ready[d]), 64'd1);
        set_ops(d, aa, bb);
        cin[d]      = c;
        in_valid[d] = 1'b1;
        @(posedge clk); #1;
        // Keep in_valid high with different operands: must be ignored.
        set_ops(d, $urandom, $urandom);
        cin[d]     = ~c;
        lat        = 0;
        ready_leak = 1'b0;
        while (!out_valid[d] && lat < 40) begin
            if (in_ready[d]) ready_leak = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("latency[%0d]", d), 64'(lat), 64'(nch[d]));
        check($sformatf("result[%0d] %0h+%0h+%0d", d, aa, bb, c), get_result(d), exp);
`ifdef MULTICYCLE_ADDER_OVF_EN
        if (wid[d] == 8) begin
            ssum    = int'($signed(aa[7:0])) + int'($signed(bb[7:0])) + int'(c);
            exp_ovf = (ssum > 127) || (ssum < -128);
            check($sformatf("ovf[%0d] %0h+%0h+%0d", d, aa[7:0], bb[7:0], c),
                  64'(ovf[d]), 64'(exp_ovf));
        end
`endif
        if (hold > 0) begin
            out_ready[d] = 1'b0;
            repeat (hold) begin
                @(posedge clk); #1;
                if (in_ready[d]) ready_leak = 1'b1;
            end
            check($sformatf("hold_valid[%0d]", d), 64'(out_valid[d]), 64'd1);
            check($sformatf("hold_result[%0d]", d), get_result(d), exp);
            out_ready[d] = 1'b1;
        end
        if (in_ready[d]) ready_leak = 1'b1;
        check($sformatf("in_ready_busy[%0d]", d), 64'(ready_leak), 64'd0);
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        check($sformatf("exit_valid[%0d]", d), 64'(out_valid[d]), 64'd0);
        check($sformatf("exit_ready[%0d]", d), 64'(in_ready[d]), 64'd1);
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rst_n[d]     = 1'b0;
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
            cin[d]       = 1'b0;
            a8[d]        = '0;
            b8[d]        = '0;
        end
        a32 = '0;
        b32 = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_in_ready[%0d]", d), 64'(in_ready[d]), 64'd1);
            check($sformatf("rst_out_valid[%0d]", d), 64'(out_valid[d]), 64'd0);
            check($sformatf("rst_result[%0d]", d), get_result(d), 64'd0);
`ifdef MULTICYCLE_ADDER_OVF_EN
            check($sformatf("rst_ovf[%0d]", d), 64'(ovf[d]), 64'd0);
`endif
        end
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) rst_n[d] = 1'b1;
        @(posedge clk); #1;

        run_txn(1, 32'hFF, 32'h01, 1'b0, 0);
        for (int i = 0; i < 20; i++) run_txn(0, $urandom, $urandom, 1'($urandom), 0);
        run_txn(0, $urandom, $urandom, 1'b1, 10);
        run_txn(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        run_txn(2, 32'h80, 32'h80, 1'b1, 0);
        for (int i = 0; i < 5; i++) run_txn(2, $urandom, $urandom, 1'($urandom), 0);
        for (int i = 0; i < 5; i++) run_txn(1, $urandom, $urandom, 1'($urandom), 0);

        // Abort a transaction after two chunks have been processed.
        set_ops(1, 32'h55, 32'h66);
        cin[1]      = 1'b1;
        in_valid[1] = 1'b1;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n[1] = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid[1]), 64'd0);
        check("abort_result", get_result(1), 64'd0);
        @(negedge clk);
        rst_n[1] = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", 64'(in_ready[1]), 64'd1);
        check("abort_stays_idle", 64'(out_valid[1]), 64'd0);
        run_txn(1, 32'h12, 32'h34, 1'b1, 0);
        check("post_abort_sum", get_result(1), 64'h047);

`ifdef MULTICYCLE_ADDER_OVF_EN
        run_txn(3, 32'h7F, 32'h01, 1'b0, 0);
        run_txn(3, 32'hFF, 32'h01, 1'b0, 0);
        for (int i = 0; i < 10; i++) run_txn(3, $urandom, $urandom, 1'($urandom), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, expected finish before 500000");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
